// File: rtl/hf_pkg.sv
// -----------------------------------------------------------------------------
// hf_pkg
// Shared definitions for the hf_compression datapath.
//   SYM_W        : width of one compression symbol (a nibble)
//   NUM_SYMS     : number of distinct symbol values
//   hist_state_e : states of the symbol-histogram controller
// -----------------------------------------------------------------------------
package hf_pkg;

  localparam int SYM_W    = 4;
  localparam int NUM_SYMS = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } hist_state_e;

endpackage : hf_pkg

// File: rtl/hf_nibble_deser.sv
// -----------------------------------------------------------------------------
// hf_nibble_deser
// Serial-to-nibble deserialiser, MSB of each symbol first.
// Ports:
//   i_clk, i_rst  : clock and synchronous active-high reset
//   i_bit         : serial data bit
//   i_bit_en      : i_bit is transferred this cycle
//   i_discard     : drop any partially assembled nibble (bit index back to 0)
//   o_sym         : assembled symbol, valid only while o_sym_valid is high
//   o_sym_valid   : single-cycle pulse on the cycle the 4th bit is accepted
// -----------------------------------------------------------------------------
module hf_nibble_deser
  import hf_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  input  logic             i_bit_en,
  input  logic             i_discard,
  output logic [SYM_W-1:0] o_sym,
  output logic             o_sym_valid
);

  logic [1:0]       r_bit_idx;
  logic [SYM_W-2:0] r_shreg;

  // The symbol is presented combinationally so the counter array can update on
  // the same edge that accepts the last bit.
  assign o_sym_valid = i_bit_en && (r_bit_idx == 2'd3);
  assign o_sym       = {r_shreg, i_bit};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_idx <= 2'd0;
      r_shreg   <= '0;
    end else if (i_discard) begin
      // A nibble completing on the discard cycle has already been emitted via
      // o_sym; whatever remains is a partial nibble and is dropped.
      r_bit_idx <= 2'd0;
      r_shreg   <= '0;
    end else if (i_bit_en) begin
      r_bit_idx <= r_bit_idx + 2'd1;
      r_shreg   <= {r_shreg[SYM_W-3:0], i_bit};
    end
  end

endmodule : hf_nibble_deser

// File: rtl/hf_symbol_histogram.sv
// -----------------------------------------------------------------------------
// hf_symbol_histogram
// Upstream stage of hf_compression. Deserialises the bit stream into 4-bit
// symbols, counts each symbol value over one page, then streams the 16
// (symbol, count) pairs to the tree-construction logic before starting the
// next page.
// Parameters:
//   PAGE_SYMS : symbols per page
//   CNT_W     : count width, must hold PAGE_SYMS
// Ports:
//   CLK, Reset   : clock and synchronous active-high reset
//   val_in       : serial data bit (MSB of each symbol first)
//   val_in_valid : val_in valid; transfers when val_in_valid && in_ready
//   in_ready     : block accepts bits (high while collecting)
//   flush        : single-cycle request to end the page early
//   sym_out      : symbol of the current histogram entry
//   cnt_out      : occurrence count of sym_out in the finished page
//   hist_valid   : histogram entry valid
//   hist_ready   : consumer accepts the entry
//   hist_last    : high with entry 15
//   page_syms    : total symbols in the page being drained
// -----------------------------------------------------------------------------
module hf_symbol_histogram
  import hf_pkg::*;
#(
  parameter int PAGE_SYMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             val_in,
  input  logic             val_in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [SYM_W-1:0] sym_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic             hist_last,
  output logic [CNT_W-1:0] page_syms
);

  if (CNT_W < $clog2(PAGE_SYMS + 1)) begin : g_bad_cnt_w
    $error("hf_symbol_histogram: CNT_W too narrow to hold PAGE_SYMS");
  end

  if (PAGE_SYMS < 1) begin : g_bad_page
    $error("hf_symbol_histogram: PAGE_SYMS must be at least 1");
  end

  localparam logic [CNT_W-1:0] PAGE_FULL  = CNT_W'(PAGE_SYMS);
  localparam logic [SYM_W-1:0] LAST_ENTRY = SYM_W'(NUM_SYMS - 1);

  hist_state_e      r_state;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] r_page_syms;
  logic [SYM_W-1:0] r_entry;
  logic [CNT_W-1:0] r_count [NUM_SYMS];

  logic             w_bit_en;
  logic             w_discard;
  logic             w_sym_valid;
  logic [SYM_W-1:0] w_sym;
  logic [CNT_W-1:0] w_sym_cnt_nxt;
  logic             w_page_full;
  logic             w_flush_end;

  assign in_ready   = (r_state == COLLECT);
  assign hist_valid = (r_state == DRAIN);

  assign w_bit_en  = val_in_valid && in_ready;
  // Flush only has meaning while collecting; in DRAIN the deserialiser is idle.
  assign w_discard = flush && in_ready;

  hf_nibble_deser u_deser (
    .i_clk       (CLK),
    .i_rst       (Reset),
    .i_bit       (val_in),
    .i_bit_en    (w_bit_en),
    .i_discard   (w_discard),
    .o_sym       (w_sym),
    .o_sym_valid (w_sym_valid)
  );

  // Symbol total including a symbol completing this cycle, so that a flush on
  // the final bit of a symbol counts it before closing the page.
  assign w_sym_cnt_nxt = r_sym_cnt + CNT_W'(w_sym_valid);
  assign w_page_full   = w_sym_valid && (w_sym_cnt_nxt == PAGE_FULL);
  assign w_flush_end   = flush && (w_sym_cnt_nxt != '0);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= COLLECT;
      r_sym_cnt   <= '0;
      r_page_syms <= '0;
      r_entry     <= '0;
      for (int i = 0; i < NUM_SYMS; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_sym_valid) begin
            r_count[w_sym] <= r_count[w_sym] + CNT_W'(1);
            r_sym_cnt      <= w_sym_cnt_nxt;
          end
          if (w_page_full || w_flush_end) begin
            r_state     <= DRAIN;
            r_page_syms <= w_sym_cnt_nxt;
            r_entry     <= '0;
          end
        end
        DRAIN: begin
          if (hist_ready) begin
            // Clearing each bin as it leaves means the array is zero by the
            // time the next page starts, with no separate clear pass.
            r_count[r_entry] <= '0;
            r_entry          <= r_entry + SYM_W'(1);
            if (r_entry == LAST_ENTRY) begin
              r_state   <= COLLECT;
              r_sym_cnt <= '0;
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign sym_out   = r_entry;
  assign cnt_out   = r_count[r_entry];
  assign hist_last = hist_valid && (r_entry == LAST_ENTRY);
  assign page_syms = r_page_syms;

endmodule : hf_symbol_histogram

// File: tb/tb_hf_symbol_histogram.sv
module tb_hf_symbol_histogram;

  localparam int PAGE_SYMS = 8;
  localparam int CNT_W     = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             val_in;
  logic             val_in_valid;
  logic             in_ready;
  logic             flush;
  logic [3:0]       sym_out;
  logic [CNT_W-1:0] cnt_out;
  logic             hist_valid;
  logic             hist_ready;
  logic             hist_last;
  logic [CNT_W-1:0] page_syms;

  always #5 CLK = ~CLK;

  hf_symbol_histogram #(
    .PAGE_SYMS (PAGE_SYMS),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .val_in       (val_in),
    .val_in_valid (val_in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .sym_out      (sym_out),
    .cnt_out      (cnt_out),
    .hist_valid   (hist_valid),
    .hist_ready   (hist_ready),
    .hist_last    (hist_last),
    .page_syms    (page_syms)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]       sym;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [CNT_W-1:0] ps;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   page_nibs[$];
  bit   bp_mode = 1'b0;
  int   bp_ph   = 0;

  // Consumer: always ready, or a 1,0,0 repeating pattern under backpressure.
  initial begin
    hist_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (bp_mode) begin
        bp_ph      = (bp_ph + 1) % 3;
        hist_ready = (bp_ph == 0);
      end else begin
        hist_ready = 1'b1;
      end
    end
  end

  // Scoreboard: entries are compared on the cycle they transfer; a stalled
  // entry must already match the head of the queue.
  always @(negedge CLK) begin
    if (!Reset && hist_valid) begin
      chk("in_ready_drain", 32'(in_ready), 0);
      if (exp_q.size() == 0) begin
        chk("extra_entry", 1, 0);
      end else if (hist_ready) begin
        mon_e = exp_q.pop_front();
        chk("sym", 32'(sym_out), 32'(mon_e.sym));
        chk("cnt", 32'(cnt_out), 32'(mon_e.cnt));
        chk("last", 32'(hist_last), 32'(mon_e.last));
        chk("page_syms", 32'(page_syms), 32'(mon_e.ps));
      end else begin
        chk("stall_sym", 32'(sym_out), 32'(exp_q[0].sym));
        chk("stall_cnt", 32'(cnt_out), 32'(exp_q[0].cnt));
      end
    end
  end

  task automatic push_expected();
    int   h [16];
    ent_t e;
    int   n;
    n = page_nibs.size();
    for (int s = 0; s < 16; s++) h[s] = 0;
    foreach (page_nibs[i]) h[page_nibs[i] & 15]++;
    if (n > 0) begin
      for (int s = 0; s < 16; s++) begin
        e.sym  = 4'(s);
        e.cnt  = CNT_W'(h[s]);
        e.last = (s == 15);
        e.ps   = CNT_W'(n);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_bit(input logic b, input logic fl);
    int n;
    n            = 0;
    val_in       = b;
    val_in_valid = 1'b1;
    flush        = fl;
    while (!in_ready && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    @(posedge CLK);
    #1;
    val_in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  // Sends page_nibs, then nparts extra bits, then an optional flush cycle.
  task automatic run_page(input int nparts, input bit do_flush, input bit flush_on_last);
    logic [3:0] nb;
    int         last_i;
    push_expected();
    last_i = page_nibs.size() - 1;
    foreach (page_nibs[i]) begin
      nb = 4'(page_nibs[i]);
      for (int b = 3; b >= 0; b--) begin
        send_bit(nb[b], flush_on_last && (i == last_i) && (b == 0));
      end
    end
    for (int p = 0; p < nparts; p++) send_bit(1'b1, 1'b0);
    if (do_flush) begin
      flush = 1'b1;
      @(posedge CLK);
      #1;
      flush = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hist_valid) && n < 500) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    Reset        = 1'b1;
    val_in       = 1'b0;
    val_in_valid = 1'b0;
    flush        = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_hist_valid", 32'(hist_valid), 0);
    chk("rst_hist_last", 32'(hist_last), 0);
    chk("rst_sym_out", 32'(sym_out), 0);
    chk("rst_cnt_out", 32'(cnt_out), 0);
    chk("rst_page_syms", 32'(page_syms), 0);

    // Normal page with full-rate drain.
    page_nibs = '{3, 3, 3, 10, 10, 15, 0, 3};
    run_page(0, 1'b0, 1'b0);
    chk("drain_entered", 32'(hist_valid), 1);
    n = 0;
    while (hist_valid && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("drain_cycles", n, 16);
    chk("in_ready_after_drain", 32'(in_ready), 1);

    // Same page under backpressure.
    bp_mode = 1'b1;
    run_page(0, 1'b0, 1'b0);
    wait_drain();
    bp_mode = 1'b0;

    // Flush with a trailing partial nibble, then an aligned full page.
    page_nibs = '{5, 5, 7};
    run_page(2, 1'b1, 1'b0);
    wait_drain();
    page_nibs = '{1, 2, 4, 8, 1, 2, 4, 8};
    run_page(0, 1'b0, 1'b0);
    wait_drain();

    // Flush on the final bit of the first symbol.
    page_nibs = '{9};
    run_page(0, 1'b0, 1'b1);
    wait_drain();

    // Flush on an empty page is ignored.
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_in_ready", 32'(in_ready), 1);
      chk("empty_flush_valid", 32'(hist_valid), 0);
      @(posedge CLK);
      #1;
    end

    // Flush with only a partial nibble: no drain, partial bits dropped.
    page_nibs = '{};
    run_page(2, 1'b1, 1'b0);
    chk("partial_flush_valid", 32'(hist_valid), 0);
    page_nibs = '{6, 6, 6, 6, 7, 7, 7, 7};
    run_page(0, 1'b0, 1'b0);
    wait_drain();

    // Back-to-back pages: bins clear as they drain.
    page_nibs = '{12, 12, 12, 12, 12, 12, 12, 12};
    run_page(0, 1'b0, 1'b0);
    page_nibs = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_page(0, 1'b0, 1'b0);
    wait_drain();

    // Reset in the middle of a drain, at entry 6.
    page_nibs = '{14, 14, 14, 14, 14, 14, 14, 14};
    run_page(0, 1'b0, 1'b0);
    n = 0;
    while (!(hist_valid && sym_out == 4'd6) && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("reach_entry6", 32'(n < 50), 1);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rst_hist_valid", 32'(hist_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_page_syms", 32'(page_syms), 0);
    Reset = 1'b0;
    exp_q.delete();
    page_nibs = '{2, 2, 2, 2, 2, 2, 2, 2};
    run_page(0, 1'b0, 1'b0);
    wait_drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hf_symbol_histogram

// File: doc/hf_symbol_histogram.md
Name: hf_symbol_histogram

Overview:
- Upstream stage of hf_compression.
- Deserialises the serial bit stream into 4-bit symbols and counts occurrences of each of the 16 symbol values over one page.
- At end of page it streams the 16 (symbol, count) pairs to the tree-construction logic with a valid/ready handshake, then starts the next page.

Parameters:
- PAGE_SYMS, 256: number of 4-bit symbols per page.
- CNT_W, 9: count width. Must satisfy CNT_W >= clog2(PAGE_SYMS+1). Elaboration error otherwise.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- val_in  in  1  serial data bit, MSB of each symbol first.
- val_in_valid  in  1  val_in is valid this cycle.
- in_ready  out  1  block accepts bits; a bit transfers when val_in_valid && in_ready.
- flush  in  1  single-cycle request to end the page early.
- sym_out  out  4  symbol value of the current histogram entry.
- cnt_out  out  CNT_W  occurrence count of sym_out in the page just finished.
- hist_valid  out  1  sym_out/cnt_out valid.
- hist_ready  in  1  consumer accepts; an entry transfers when hist_valid && hist_ready.
- hist_last  out  1  high with entry 15.
- page_syms  out  CNT_W  total symbols in the page being drained; held for the whole drain.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; the clock port is CLK and the reset port is Reset.
- Reset (any state, including mid-drain): state=COLLECT, bit_idx=0, sym_cnt=0, all 16 counts=0, shift reg=0, hist_valid=0, hist_last=0, sym_out=0, cnt_out=0, page_syms=0.
- States: COLLECT, DRAIN.
- in_ready = (state==COLLECT).
- hist_valid = (state==DRAIN).
- COLLECT:
  - Each accepted bit shifts into a 3-bit shift reg; bit_idx increments mod 4.
  - When the 4th bit is accepted, symbol = {shreg, val_in}.
  - That cycle, count[symbol] += 1 and sym_cnt += 1.
  - The counted symbol is visible in count[] on the next cycle (1-cycle latency).
- End of page (COLLECT->DRAIN):
  - Normal end: sym_cnt reaches PAGE_SYMS. The transition happens on the edge that counts the last symbol.
  - Flush end: flush=1 and sym_cnt (including any symbol completing that same cycle) > 0.
  - A partial nibble (bit_idx != 0, not completing) is discarded on flush.
  - flush with zero symbols is ignored; a partial nibble is still discarded.
  - flush and the final bit of a symbol in the same cycle: the symbol is counted first, then the page ends.
  - Entering DRAIN: page_syms <= final sym_cnt; entry index e=0; bit_idx=0.
- DRAIN:
  - sym_out=e, cnt_out=count[e], hist_last=(e==15).
  - Outputs hold stable while hist_ready=0.
  - On handshake: count[e] is cleared to 0 and e increments.
  - On handshake with e==15: state<=COLLECT and sym_cnt<=0.
  - Input bits are stalled (in_ready=0); flush is ignored in DRAIN.
  - Zero-count entries are still emitted; all 16 entries are always sent.
- Invariant: sum of the 16 cnt_out values in a drain == page_syms.
- No saturation is needed, since CNT_W holds PAGE_SYMS.
- Throughput: one entry per cycle when hist_ready is held high, so a drain takes exactly 16 cycles. The first bit of the next page is accepted the cycle after the last handshake.

Decomposition:
- Package hf_pkg: SYM_W=4, NUM_SYMS=16, hist state enum {COLLECT, DRAIN}. hf_compression also uses SYM_W and NUM_SYMS.
- One sub-module, hf_nibble_deser: serial-to-4-bit deserialiser. It has bit_idx and the shift reg, a sym_valid pulse output, and a discard input driven by flush.
- Counter array, sym_cnt and the FSM stay in hf_symbol_histogram.

Test Plan:
- Reset then PAGE_SYMS=8: send nibbles 3,3,3,A,A,F,0,3 back-to-back, hist_ready=1 -> 16 entries over 16 cycles with cnt[0]=1, cnt[3]=4, cnt[A]=2, cnt[F]=1, others 0. hist_last only on sym 15; page_syms=8.
- Backpressure: same page with hist_ready toggled 1,0,0,1,... -> each entry held stable while stalled; no entry lost or duplicated; in_ready=0 throughout the drain.
- Flush: 3 nibbles 5,5,7 then 2 bits, then flush -> page_syms=3, cnt[5]=2, cnt[7]=1. The next page starts at bit_idx 0 (partial bits discarded).
- Flush on the same cycle as the 4th bit of nibble 9 (first symbol) -> page_syms=1, cnt[9]=1. flush in an empty page with no bits -> no drain, in_ready stays 1.
- Back-to-back pages: page 1 all 0xC, page 2 all 0x1 -> page 2 drain shows cnt[C]=0 and cnt[1]=8, proving counts clear during drain.
- Reset asserted at entry e=6 of a drain -> next cycle hist_valid=0 and in_ready=1. The following page's histogram contains only the new symbols.
